// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
//   arb_state_e      : arbiter FSM states
//   DEF_*            : default parameter values
//   wrap_inc()       : cyclic index increment
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_MAX_BURST  = 4;
   localparam int DEF_DATA_WIDTH = 16;

   // idx+1 modulo n, without a divider
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    in  : request vector
//   ptr    in  : highest-priority index this round
//   grant  out : one-hot grant (all zero if no request)
//   winner out : index of the granted request
//   any    out : at least one request present
module fifo_wr_arbiter_rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      winner,
   output logic               any
);

   int idx;

   // Scan from ptr upward, wrapping; the first hit wins.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            winner     = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/data/ready : per-producer valid/ready handshake
//   full, almostfull     : FIFO back-pressure flags
//   overflow             : FIFO dropped-write indication
//   wr_en, data_in       : registered FIFO write port
//   owner                : current burst owner
//   err_drop             : sticky overflow seen
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = DEF_NUM_REQ,
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int MAX_BURST  = DEF_MAX_BURST,
   localparam int IW         = $clog2(NUM_REQ),
   localparam int CW         = $clog2(MAX_BURST + 1)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic                                full,
   input  logic                                almostfull,
   input  logic                                overflow,
   output logic                                wr_en,
   output logic [DATA_WIDTH-1:0]               data_in,
   output logic [IW-1:0]                       owner,
   output logic                                err_drop
);

   arb_state_e         state;
   logic [IW-1:0]      rr_ptr;
   logic [CW-1:0]      burst_cnt;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   logic               can_write;
   logic               accept;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] ready_c;

   fifo_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .grant  (pick_grant),
      .winner (pick_idx),
      .any    (pick_any)
   );

   // The flags lag a registered write by one cycle; a pending wr_en with
   // almostfull means the last slot is already spoken for.
   assign can_write = !full && !(wr_en && almostfull);

   always_comb begin
      ready_c = '0;
      accept  = 1'b0;
      win_idx = owner;
      case (state)
         IDLE: begin
            if (pick_any && can_write) begin
               ready_c = pick_grant;
               accept  = 1'b1;
               win_idx = pick_idx;
            end
         end
         BURST: begin
            if (req_valid[owner] && can_write && burst_cnt < CW'(MAX_BURST)) begin
               ready_c[owner] = 1'b1;
               accept         = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign req_ready = rst_n ? ready_c : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         wr_en     <= 1'b0;
         data_in   <= '0;
         err_drop  <= 1'b0;
      end else begin
         if (overflow) err_drop <= 1'b1;
         wr_en <= accept;
         if (accept) data_in <= req_data[win_idx];
         case (state)
            IDLE: begin
               if (accept) begin
                  owner     <= pick_idx;
                  burst_cnt <= CW'(1);
                  // Single-beat bursts never enter BURST; rotate right away.
                  if (MAX_BURST == 1) rr_ptr <= IW'(wrap_inc(int'(pick_idx), NUM_REQ));
                  else                state  <= BURST;
               end
            end
            BURST: begin
               if (!req_valid[owner] || burst_cnt == CW'(MAX_BURST)) begin
                  rr_ptr <= IW'(wrap_inc(int'(owner), NUM_REQ));
                  state  <= IDLE;
               end else if (accept) begin
                  burst_cnt <= burst_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the project FIFO among NUM_REQ independent producers. Each producer uses a valid/ready handshake. The arbiter grants bursts of up to MAX_BURST beats per owner, applies back-pressure from the FIFO `full`/`almostfull` flags, and drives the FIFO `wr_en`/`data_in` from registers. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- NUM_REQ, default 4: number of producers, minimum 2.
- DATA_WIDTH, default 16: data width; must equal the FIFO width.
- MAX_BURST, default 4: maximum consecutive beats granted to one owner, minimum 1.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  producer i has a beat on req_data[i].
- req_data  in  NUM_REQ x DATA_WIDTH  producer payloads.
- req_ready  out  NUM_REQ  at most one bit high; beat i is accepted when req_valid[i] & req_ready[i].
- full  in  1  FIFO full flag.
- almostfull  in  1  FIFO has exactly one free slot.
- overflow  in  1  FIFO reports a dropped write (one cycle after the write).
- wr_en  out  1  registered FIFO write strobe.
- data_in  out  DATA_WIDTH  registered FIFO write data.
- owner  out  $clog2(NUM_REQ)  index of the current burst owner; valid while in BURST.
- err_drop  out  1  sticky; set when `overflow` is seen.

## Operation
- FSM states:
  - IDLE: no owner.
  - BURST: `owner` holds the port.
- Space check: `can_write = !full && !(wr_en && almostfull)`. This covers the write already registered but not yet reflected in the flags.
- IDLE:
  - If any req_valid and can_write: pick the first valid index at or after rr_ptr, cyclically.
  - Assert req_ready for that index in the same cycle, load owner, set burst_cnt=1, go to BURST.
  - If MAX_BURST=1, stay in IDLE and advance rr_ptr to winner+1.
- BURST:
  - If req_valid[owner] and can_write and burst_cnt<MAX_BURST: req_ready[owner]=1 and burst_cnt increments.
  - If req_valid[owner] is low, or burst_cnt==MAX_BURST: set rr_ptr=owner+1 mod NUM_REQ, go to IDLE, and accept no beat that cycle.
  - If !can_write: stall with ready low, owner held, burst_cnt unchanged.
- Every accepted beat: wr_en<=1 and data_in<=req_data[winner] on the next edge. Otherwise wr_en<=0 and data_in holds its value.
- err_drop sets on any cycle with overflow=1 and is cleared only by reset.
- Reset values: state IDLE, rr_ptr 0, owner 0, burst_cnt 0, wr_en 0, data_in 0, err_drop 0.
- req_ready is forced to 0 while rst_n=0.

## Timing
- Acceptance to wr_en: exactly 1 cycle. Sustained throughput is 1 beat/cycle within a burst.
- Gaps in accepted beats:
  - Burst handover: 1 idle cycle (BURST→IDLE), then the new grant.
  - Fresh grant from IDLE: 0 idle cycles.
- req_ready depends combinationally on req_valid, full, almostfull and registered state. Producers must not make req_valid depend on req_ready.
- Producer data must stay stable while req_valid is high and req_ready is low.
- Fill boundary: when almostfull=1 and wr_en=1, ready is deasserted, so the FIFO is never written while full. Overflow therefore indicates an external fault.
- Reset mid-burst: the registered in-flight beat is discarded (wr_en clears immediately on reset), arbitration restarts at index 0, and producers must re-present the beat.
- Simultaneous requests in IDLE: rr_ptr decides; a lower index never wins out of turn.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure
- shared_pkg additions: typedef enum arb_state_e {IDLE, BURST}, and defaults for NUM_REQ and MAX_BURST.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and the winner index.
- Top-level block holds the FSM, burst counter, output registers and err_drop.

## Test plan
- Single producer 0 streams 10 beats 0x0001..0x000A into an empty FIFO (depth 8, reader idle) → 7 beats written, the 8th writes with almostfull, then ready stays low; err_drop=0.
- All 4 producers valid, reader draining each cycle, MAX_BURST=4 → owner sequence 0,1,2,3,0. Each burst is 4 beats, with one gap cycle between bursts.
- Producer 2 drops valid after 2 beats while 3 is waiting → handover to 3 after 1 idle cycle; rr_ptr=3.
- rst_n pulsed low mid-burst of producer 1 (beat 3 registered) → wr_en=0 asynchronously; after release, producers 1 and 3 valid → producer 1 wins (rr_ptr=0, first valid at or after 0).
- Force overflow=1 for one cycle → err_drop=1 and stays 1 until reset.
- Random valid patterns, 10000 cycles → never more than one req_ready high, never wr_en with full=1, and FIFO output order matches per-producer input order.
